// File: rtl/bram_block_store_pkg.sv
// Shared types and constants for the block-RAM backed block store.
// Optional stall-LFSR constants exist only under BRAM_BLOCK_STORE_STALL_EN.
package bram_block_store_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StReadFill,
    StRead
  } state_e;

  localparam int unsigned FifoDepth = 2;

`ifdef BRAM_BLOCK_STORE_STALL_EN
  localparam logic [5:0] LfsrSeed     = 6'd1;
  localparam logic [5:0] LfsrStallMin = 6'd56;

  // Fibonacci LFSR, polynomial x^6 + x^5 + 1
  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction
`endif

endpackage

// File: rtl/bram_block_store_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Written in the plain form that maps onto iCE40 EBR.
module bram_block_store_mem #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned WordWidth = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [WordWidth-1:0] wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [WordWidth-1:0] rdata
);

  logic [WordWidth-1:0] mem [2**AddrWidth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_block_store.sv
// Block cmd/data responder backed by on-chip RAM, stand-in for the SDRAM controller.
// Define BRAM_BLOCK_STORE_STALL_EN to inject pseudo-random data_ready stalls.
module bram_block_store
  import bram_block_store_pkg::*;
#(
  parameter int unsigned BlockSize  = 16,
  parameter int unsigned BlockCount = 256,
  parameter int unsigned WordWidth  = 16,
  localparam int unsigned BlockWidth = $clog2(BlockCount),
  localparam int unsigned IdxWidth   = $clog2(BlockSize),
  localparam int unsigned AddrWidth  = BlockWidth + IdxWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  cmd_ready,
  input  logic                  cmd_trigger,
  input  logic [BlockWidth-1:0] cmd_block,
  input  logic                  cmd_write,
  output logic                  data_ready,
  input  logic                  data_trigger,
  input  logic [WordWidth-1:0]  data_write,
  output logic [WordWidth-1:0]  data_read
);

  state_e                state_q, state_d;
  logic [BlockWidth-1:0] blk_q, blk_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [IdxWidth:0]     iss_q, iss_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WordWidth-1:0]  b0_q, b0_d, b1_q, b1_d;
  logic                  rvalid_q;
  logic [WordWidth-1:0]  rdata;

  logic       stall, accept, xfer, last, in_read, avail, issue, pop_fifo, push;
  logic [1:0] wpos;

`ifdef BRAM_BLOCK_STORE_STALL_EN
  logic [5:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LfsrSeed;
    else     lfsr_q <= lfsr_step(lfsr_q);
  end

  assign stall = (lfsr_q >= LfsrStallMin);
`else
  assign stall = 1'b0;
`endif

  // Words on hand are the FIFO plus the one arriving from the RAM this cycle.
  always_comb begin
    in_read    = (state_q == StReadFill) || (state_q == StRead);
    avail      = (cnt_q != 2'd0) || rvalid_q;
    cmd_ready  = (state_q == StIdle);
    data_ready = ((state_q == StWrite) || (in_read && avail)) && !stall;
    data_read  = '0;
    if (in_read && avail) data_read = (cnt_q != 2'd0) ? b0_q : rdata;
  end

  assign accept   = cmd_ready && cmd_trigger;
  assign xfer     = data_ready && data_trigger;
  assign last     = (idx_q == IdxWidth'(BlockSize - 1));
  assign issue    = in_read && !iss_q[IdxWidth] &&
                    ((32'(cnt_q) + 32'(rvalid_q)) < FifoDepth);
  assign pop_fifo = xfer && in_read && (cnt_q != 2'd0);
  assign push     = rvalid_q && !(xfer && (cnt_q == 2'd0));
  assign wpos     = cnt_q - {1'b0, pop_fifo};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (accept) state_d = cmd_write ? StWrite : StReadFill;
      StWrite:    if (xfer && last) state_d = StIdle;
      StReadFill: begin
        if (xfer && last)  state_d = StIdle;
        else if (rvalid_q) state_d = StRead;
      end
      StRead:     if (xfer && last) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    blk_d = blk_q;
    idx_d = idx_q;
    iss_d = iss_q;
    cnt_d = cnt_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    if (accept) begin
      blk_d = cmd_block;
      idx_d = '0;
      iss_d = '0;
      cnt_d = '0;
    end else begin
      if (xfer)     idx_d = idx_q + 1'b1;
      if (issue)    iss_d = iss_q + 1'b1;
      if (pop_fifo) b0_d  = b1_q;
      if (push) begin
        if (wpos == 2'd0) b0_d = rdata;
        else              b1_d = rdata;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q    <= '0;
      idx_q    <= '0;
      iss_q    <= '0;
      cnt_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      iss_q    <= iss_d;
      cnt_q    <= cnt_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      rvalid_q <= issue;
    end
  end

  bram_block_store_mem #(
    .AddrWidth (AddrWidth),
    .WordWidth (WordWidth)
  ) u_mem (
    .clk   (clk),
    .we    (xfer && (state_q == StWrite)),
    .waddr ({blk_q, idx_q}),
    .wdata (data_write),
    .re    (issue),
    .raddr ({blk_q, iss_q[IdxWidth-1:0]}),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_bram_block_store.sv
// Directed bench for bram_block_store with a transaction-level memory model.
module tb_bram_block_store;

  localparam int BS = 16;
  localparam int BC = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_trigger = 1'b0;
  logic [7:0]  cmd_block = 8'd0;
  logic        cmd_write = 1'b0;
  logic        data_trigger = 1'b0;
  logic [15:0] data_write = 16'd0;
  logic        cmd_ready;
  logic        data_ready;
  logic [15:0] data_read;

  bram_block_store dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_ready    (cmd_ready),
    .cmd_trigger  (cmd_trigger),
    .cmd_block    (cmd_block),
    .cmd_write    (cmd_write),
    .data_ready   (data_ready),
    .data_trigger (data_trigger),
    .data_write   (data_write),
    .data_read    (data_read)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a block is a flat array of words; a command is BS ordered transfers.
  logic [15:0] mdl   [BS*BC];
  bit          known [BS*BC];
  bit          m_active = 1'b0;
  bit          m_wr = 1'b0;
  int          m_blk = 0;
  int          m_idx = 0;
  logic [15:0] cap [BS];

  always @(negedge clk) begin
    int a;
    if (rst) begin
      m_active = 1'b0;
    end else begin
      check("cmd_ready_vs_model", 32'(cmd_ready), 32'(!m_active));
      if (!m_active) check("data_ready_idle", 32'(data_ready), 32'd0);
      if (m_active && data_ready && data_trigger) begin
        a = m_blk * BS + m_idx;
        if (m_wr) begin
          mdl[a]   = data_write;
          known[a] = 1'b1;
        end else if (known[a]) begin
          check($sformatf("rd_word_b%0d_i%0d", m_blk, m_idx), 32'(data_read), 32'(mdl[a]));
        end
        m_idx++;
        if (m_idx == BS) m_active = 1'b0;
      end else if (!m_active && cmd_ready && cmd_trigger) begin
        m_active = 1'b1;
        m_wr     = cmd_write;
        m_blk    = int'(cmd_block);
        m_idx    = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after accept.
  task automatic issue_cmd(input int blk, input bit wr, input string tag);
    cmd_block   = 8'(blk);
    cmd_write   = wr;
    cmd_trigger = 1'b1;
    @(negedge clk);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_idle_data_ready"}, 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    cmd_trigger = 1'b0;
  endtask

  task automatic write_block(input int blk, input logic [15:0] base, input bit inc,
                             input int nmax, input string tag);
    int i = 0;
    int cyc = 0;
    bit x;
    issue_cmd(blk, 1'b1, tag);
    data_trigger = 1'b1;
    while (i < nmax && cyc < 200) begin
      data_write = base + (inc ? 16'(i) : 16'h0);
      @(negedge clk);
      x = data_ready;
`ifndef BRAM_BLOCK_STORE_STALL_EN
      if (cyc == 0) check({tag, "_ready_at_accept_plus1"}, 32'(x), 32'd1);
`endif
      @(posedge clk); #1;
      if (x) i++;
      cyc++;
    end
    data_trigger = 1'b0;
    check({tag, "_transfers"}, 32'(i), 32'(nmax));
`ifndef BRAM_BLOCK_STORE_STALL_EN
    if (nmax == BS) check({tag, "_cycles"}, 32'(cyc), 32'(BS));
`endif
  endtask

  task automatic read_block(input int blk, input bit toggle, input string tag);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    bit x;
    issue_cmd(blk, 1'b0, tag);
    data_trigger = !toggle;
    @(negedge clk);
`ifndef BRAM_BLOCK_STORE_STALL_EN
    check({tag, "_not_ready_accept_plus1"}, 32'(data_ready), 32'd0);
`endif
    @(posedge clk); #1;
    while (i < BS && cyc < 200) begin
      data_trigger = toggle ? !ph : 1'b1;
      @(negedge clk);
      x = data_ready && data_trigger;
      if (x) cap[i] = data_read;
`ifndef BRAM_BLOCK_STORE_STALL_EN
      if (cyc == 0) check({tag, "_ready_at_accept_plus2"}, 32'(data_ready), 32'd1);
`endif
      @(posedge clk); #1;
      if (x) i++;
      cyc++;
      ph = !ph;
    end
    data_trigger = 1'b0;
    check({tag, "_transfers"}, 32'(i), 32'(BS));
`ifndef BRAM_BLOCK_STORE_STALL_EN
    if (!toggle) check({tag, "_cycles"}, 32'(cyc), 32'(BS));
`else
    check({tag, "_cycles_at_least"}, 32'(cyc >= BS), 32'd1);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_data_ready", 32'(data_ready), 32'd0);
    check("reset_data_read", 32'(data_read), 32'd0);
    @(posedge clk); #1;

    write_block(3, 16'hA000, 1'b1, BS, "t1_wr3");
    read_block(3, 1'b0, "t2_rd3");
    check("t2_first_word", 32'(cap[0]), 32'h0000A000);
    check("t2_last_word", 32'(cap[15]), 32'h0000A00F);
    read_block(3, 1'b1, "t3_rd3_toggle");
    check("t3_word9", 32'(cap[9]), 32'h0000A009);
    check("t3_last_word", 32'(cap[15]), 32'h0000A00F);

    write_block(0, 16'h1111, 1'b0, BS, "t4_wr0");
    write_block(255, 16'h2222, 1'b0, BS, "t4_wr255");
    read_block(0, 1'b0, "t4_rd0");
    check("t4_blk0_word0", 32'(cap[0]), 32'h00001111);
    check("t4_blk0_word15", 32'(cap[15]), 32'h00001111);
    read_block(255, 1'b0, "t4_rd255");
    check("t4_blk255_word0", 32'(cap[0]), 32'h00002222);
    check("t4_blk255_word15", 32'(cap[15]), 32'h00002222);

    write_block(5, 16'h5500, 1'b1, BS, "t5_wr5");
    write_block(5, 16'hFF00, 1'b1, 5, "t5_rewrite");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    read_block(5, 1'b0, "t5_rd5_after_rst");
    check("t5_word0", 32'(cap[0]), 32'h0000FF00);
    check("t5_word4", 32'(cap[4]), 32'h0000FF04);
    check("t5_word5", 32'(cap[5]), 32'h00005505);
    check("t5_word15", 32'(cap[15]), 32'h0000550F);

    @(negedge clk);
    check("end_cmd_ready", 32'(cmd_ready), 32'd1);
    check("end_data_ready", 32'(data_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
